// File: rtl/mul_pkg.sv
// Shared widths and FSM state encoding for the two-requester multiplier arbiter.
package mul_pkg;

    localparam int OPND_W   = 32;
    localparam int RESULT_W = 64;
    localparam int CNT_W    = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner selection; purely combinational.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    // On contention the requester that was not served last time wins.
    assign gnt0 = req0 & (~req1 | last_grant);
    assign gnt1 = req1 & (~req0 | ~last_grant);

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates two requesters onto one shared multiplier, one operation at a time,
// with a timeout abort when the multiplier never reports completion.
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic [OPND_W-1:0]   a0,
    input  logic [OPND_W-1:0]   b0,
    input  logic [OPND_W-1:0]   a1,
    input  logic [OPND_W-1:0]   b1,
    output logic                ack0,
    output logic                ack1,
    output logic                err0,
    output logic                err1,
    output logic [RESULT_W-1:0] result,
    output logic                busy,
    output logic                mul_go,
    output logic [OPND_W-1:0]   mul_a,
    output logic [OPND_W-1:0]   mul_b,
    input  logic                mul_done,
    input  logic [RESULT_W-1:0] mul_result
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_grant;
    logic                r_last_grant;
    logic [OPND_W-1:0]   r_mul_a;
    logic [OPND_W-1:0]   r_mul_b;
    logic [RESULT_W-1:0] r_result;
    logic                r_err0;
    logic                r_err1;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_abort;

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (r_last_grant),
        .gnt0       (w_gnt0),
        .gnt1       (w_gnt1)
    );

    assign w_abort = (r_state == ST_WAIT) && !mul_done && (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (req0 || req1) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (mul_done)     w_next_state = ST_RESP;
                else if (w_abort) w_next_state = ST_IDLE;
            end
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        mul_go = (r_state == ST_ISSUE);
        busy   = (r_state != ST_IDLE);
        ack0   = (r_state == ST_RESP) && !r_grant;
        ack1   = (r_state == ST_RESP) &&  r_grant;
    end

    // Operands, grant bookkeeping, wait counter and the registered error pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_result     <= '0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
        end else begin
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_grant <= w_gnt1;
                        r_mul_a <= w_gnt1 ? a1 : a0;
                        r_mul_b <= w_gnt1 ? b1 : b0;
                    end
                end
                ST_ISSUE: r_cnt <= '0;
                ST_WAIT: begin
                    if (mul_done) begin
                        r_result <= mul_result;
                    end else if (w_abort) begin
                        r_err0       <= ~r_grant;
                        r_err1       <=  r_grant;
                        r_last_grant <=  r_grant;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: r_last_grant <= r_grant;
                default: ;
            endcase
        end
    end

    assign mul_a  = r_mul_a;
    assign mul_b  = r_mul_b;
    assign result = r_result;
    assign err0   = r_err0;
    assign err1   = r_err1;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a 4-cycle multiplier model.
module tb_mul_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        ack0, ack1, err0, err1, busy, mul_go, mul_done;
    logic [63:0] result, mul_result;
    logic [31:0] mul_a, mul_b;

    logic        done_en = 1'b1;
    logic        force_done = 1'b0;
    logic [3:0]  r_go_sr;
    logic [63:0] r_prod;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    mul_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .ack0       (ack0),
        .ack1       (ack1),
        .err0       (err0),
        .err1       (err1),
        .result     (result),
        .busy       (busy),
        .mul_go     (mul_go),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    // Multiplier model: done exactly 4 cycles after go, reset by the same signal.
    always @(posedge clk) begin
        if (!reset) begin
            r_go_sr <= '0;
            r_prod  <= '0;
        end else begin
            r_go_sr <= {r_go_sr[2:0], mul_go};
            if (mul_go) r_prod <= {32'd0, mul_a} * {32'd0, mul_b};
        end
    end
    assign mul_done   = (r_go_sr[3] & done_en) | force_done;
    assign mul_result = r_prod;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", {58'd0, ack0, ack1, err0, err1, mul_go, busy}, 64'd0);
        chk("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        chk("rst_result", result, 64'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic single_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp, input string tag);
        int go_at, ack_at, wrong;
        go_at  = -1;
        ack_at = -1;
        wrong  = 0;
        @(negedge clk);
        if (sel) begin a1 = a; b1 = b; req1 = 1'b1; end
        else     begin a0 = a; b0 = b; req0 = 1'b1; end
        for (int k = 1; k <= 20 && ack_at < 0; k++) begin
            @(negedge clk);
            if (mul_go && go_at < 0) go_at = k;
            if ((sel ? ack0 : ack1) || err0 || err1) wrong++;
            if (sel ? ack1 : ack0) begin
                ack_at = k;
                chk({tag, "_result"}, result, exp);
                chk({tag, "_opnds"}, {mul_a, mul_b}, {a, b});
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk({tag, "_go_lat"}, 64'(go_at), 64'd1);
        chk({tag, "_ack_lat"}, 64'(ack_at), 64'd6);
        chk({tag, "_stray"}, 64'(wrong), 64'd0);
        @(negedge clk);
        chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic idle_done_test(input logic [63:0] prev);
        @(negedge clk);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        chk("idle_done_busy", {62'd0, busy, ack0 | ack1}, 64'd0);
        @(negedge clk);
        chk("idle_done_quiet", {62'd0, busy, ack0 | ack1}, 64'd0);
        chk("result_hold", result, prev);
    endtask

    task automatic contention_test();
        int          n;
        int          who[2];
        logic [63:0] res[2];
        n = 0;
        who = '{-1, -1};
        res = '{64'd0, 64'd0};
        do_reset();
        @(negedge clk);
        a0 = 32'd2; b0 = 32'd7; a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 40 && n < 2; k++) begin
            @(negedge clk);
            if (ack0) begin who[n] = 0; res[n] = result; n++; req0 = 1'b0; end
            else if (ack1) begin who[n] = 1; res[n] = result; n++; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("cont_count", 64'(n), 64'd2);
        chk("cont_first", 64'(who[0]), 64'd0);
        chk("cont_first_res", res[0], 64'd14);
        chk("cont_second", 64'(who[1]), 64'd1);
        chk("cont_second_res", res[1], 64'hFFFF_FFFE_0000_0001);
    endtask

    task automatic fairness_test();
        int seq[$];
        do_reset();
        @(negedge clk);
        a0 = 32'd100; b0 = 32'd3; a1 = 32'h1234_5678; b1 = 32'd16;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 100 && seq.size() < 6; k++) begin
            @(negedge clk);
            if (ack0) begin seq.push_back(0); chk("fair_res0", result, 64'd300); end
            if (ack1) begin seq.push_back(1); chk("fair_res1", result, 64'h1_2345_6780); end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("fair_count", 64'(seq.size()), 64'd6);
        foreach (seq[i]) chk("fair_order", 64'(seq[i]), 64'(i % 2));
        @(negedge clk);
    endtask

    task automatic timeout_test();
        int   err_at, pulses, stray;
        logic busy_at_err;
        err_at = -1; pulses = 0; stray = 0; busy_at_err = 1'b1;
        done_en = 1'b0;
        @(negedge clk);
        a1 = 32'd77; b1 = 32'd5; req1 = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ack0 || ack1 || err0) stray++;
            if (err1) begin
                pulses++;
                if (err_at < 0) begin err_at = k; busy_at_err = busy; end
                req1 = 1'b0;
            end
        end
        req1 = 1'b0;
        chk("tmo_err_at", 64'(err_at), 64'(TIMEOUT + 2));
        chk("tmo_pulses", 64'(pulses), 64'd1);
        chk("tmo_stray", 64'(stray), 64'd0);
        chk("tmo_idle", {63'd0, busy_at_err}, 64'd0);
        done_en = 1'b1;
        single_op(1'b0, 32'd6, 32'd7, 64'd42, "after_tmo");
    endtask

    task automatic reset_mid_wait_test();
        int stray;
        stray = 0;
        @(negedge clk);
        a0 = 32'd9; b0 = 32'd9; req0 = 1'b1;
        @(negedge clk);
        chk("rmw_go", {63'd0, mul_go}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        req0  = 1'b0;
        @(negedge clk);
        chk("rmw_ctrl", {58'd0, ack0, ack1, err0, err1, mul_go, busy}, 64'd0);
        chk("rmw_mul_ab", {mul_a, mul_b}, 64'd0);
        chk("rmw_result", result, 64'd0);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack0 || ack1 || err0 || err1) stray++;
        end
        chk("rmw_no_resp", 64'(stray), 64'd0);
        single_op(1'b0, 32'd12, 32'd11, 64'd132, "after_rst");
    endtask

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'd0;
            default: return $urandom();
        endcase
    endfunction

    // Transaction-level reference: one operation at a time, fixed 6-cycle turnaround
    // from the sampling cycle to ack, round-robin by last served requester.
    task automatic random_test(input int ncyc);
        bit          rq[2];
        logic [31:0] ra[2], rb[2];
        int          last, free_at, g, w;
        logic [63:0] er;
        bit          e_go, e_busy, e_ack;
        rq = '{1'b0, 1'b0};
        ra = '{32'd0, 32'd0};
        rb = '{32'd0, 32'd0};
        last = 1; free_at = 0; g = -100; w = 0; er = '0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            e_go   = (c == g + 1);
            e_busy = (c >= g + 1) && (c <= g + 6);
            e_ack  = (c == g + 6);
            chk("rnd_go", {63'd0, mul_go}, {63'd0, e_go});
            chk("rnd_busy", {63'd0, busy}, {63'd0, e_busy});
            chk("rnd_ack", {62'd0, ack1, ack0}, e_ack ? (w == 1 ? 64'd2 : 64'd1) : 64'd0);
            chk("rnd_err", {62'd0, err1, err0}, 64'd0);
            if (e_ack) chk("rnd_result", result, er);
            for (int i = 0; i < 2; i++) begin
                if (e_ack && w == i) rq[i] = 1'b0;
                else if (!rq[i] && $urandom_range(0, 2) == 0) begin
                    rq[i] = 1'b1;
                    ra[i] = pick_opnd();
                    rb[i] = pick_opnd();
                end
            end
            req0 = rq[0]; a0 = ra[0]; b0 = rb[0];
            req1 = rq[1]; a1 = ra[1]; b1 = rb[1];
            if (c >= free_at && (rq[0] || rq[1])) begin
                w       = (rq[0] && rq[1]) ? 1 - last : (rq[1] ? 1 : 0);
                last    = w;
                g       = c;
                free_at = c + 7;
                er      = 64'(ra[w]) * 64'(rb[w]);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd3,          32'd5,          64'd15};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{1'b0, 32'd0,          32'd123,        64'd0};
        vecs[3] = '{1'b1, 32'h0001_0000,  32'h0001_0000,  64'h1_0000_0000};
        vecs[4] = '{1'b0, 32'h8000_0000,  32'd2,          64'h1_0000_0000};

        do_reset();
        for (int i = 0; i < 5; i++)
            single_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        idle_done_test(vecs[4].exp);
        contention_test();
        fairness_test();
        timeout_test();
        reset_mid_wait_test();
        random_test(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
